// File: rtl/mpeg_muxer.sv
// mpeg_muxer: packs elementary-stream bytes into an MPEG-1 system stream
// (pack header, PES header with optional PTS, payload passthrough, end code).
module mpeg_muxer #(
    parameter logic [21:0] MUX_RATE = 22'd3528
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_pack,
    input  logic [32:0] cmd_scr,
    input  logic [7:0]  cmd_stream_id,
    input  logic [15:0] cmd_length,
    input  logic        cmd_pts_valid,
    input  logic [32:0] cmd_pts,
    input  logic        cmd_end,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_PACK_SC, S_SCR, S_MUXR, S_PES_SC,
        S_PES_LEN, S_PTS, S_NOPTS, S_PAYLOAD, S_END_SC
    } state_t;

    state_t      state_q, state_d, hdr_next;
    logic [2:0]  idx_q, idx_d, last_idx;
    logic [15:0] rem_q, rem_d, pes_len;
    logic [32:0] scr_q, scr_d, pts_q, pts_d;
    logic [7:0]  id_q, id_d;
    logic        pts_valid_q, pts_valid_d;
    logic [7:0]  out_data_q, out_data_d, hdr_byte;
    logic        out_valid_q, out_valid_d;
    logic        load;

    // SCR and PTS share the 33-bit timestamp layout with marker bits.
    function automatic logic [7:0] ts_byte(input logic [32:0] v, input logic [2:0] i);
        case (i)
            3'd0:    ts_byte = {4'b0010, v[32:30], 1'b1};
            3'd1:    ts_byte = v[29:22];
            3'd2:    ts_byte = {v[21:15], 1'b1};
            3'd3:    ts_byte = v[14:7];
            default: ts_byte = {v[6:0], 1'b1};
        endcase
    endfunction

    function automatic logic [7:0] sc_byte(input logic [7:0] code, input logic [2:0] i);
        case (i)
            3'd0, 3'd1: sc_byte = 8'h00;
            3'd2:       sc_byte = 8'h01;
            default:    sc_byte = code;
        endcase
    endfunction

    assign load      = !out_valid_q || out_ready;
    assign cmd_ready = (state_q == S_IDLE);
    assign in_ready  = (state_q == S_PAYLOAD) && load;
    assign busy      = (state_q != S_IDLE) || out_valid_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign pes_len   = rem_q + (pts_valid_q ? 16'd5 : 16'd1);

    always_comb begin
        hdr_byte = '0;
        last_idx = '0;
        hdr_next = S_IDLE;
        case (state_q)
            S_PACK_SC: begin hdr_byte = sc_byte(8'hBA, idx_q); last_idx = 3'd3; hdr_next = S_SCR;    end
            S_SCR:     begin hdr_byte = ts_byte(scr_q, idx_q); last_idx = 3'd4; hdr_next = S_MUXR;   end
            S_MUXR: begin
                case (idx_q)
                    3'd0:    hdr_byte = {1'b1, MUX_RATE[21:15]};
                    3'd1:    hdr_byte = MUX_RATE[14:7];
                    default: hdr_byte = {MUX_RATE[6:0], 1'b1};
                endcase
                last_idx = 3'd2;
                hdr_next = S_PES_SC;
            end
            S_PES_SC:  begin hdr_byte = sc_byte(id_q, idx_q);  last_idx = 3'd3; hdr_next = S_PES_LEN; end
            S_PES_LEN: begin
                hdr_byte = (idx_q == 3'd0) ? pes_len[15:8] : pes_len[7:0];
                last_idx = 3'd1;
                hdr_next = pts_valid_q ? S_PTS : S_NOPTS;
            end
            S_PTS: begin
                hdr_byte = ts_byte(pts_q, idx_q);
                last_idx = 3'd4;
                hdr_next = (rem_q == '0) ? S_IDLE : S_PAYLOAD;
            end
            S_NOPTS: begin
                hdr_byte = 8'h0F;
                hdr_next = (rem_q == '0) ? S_IDLE : S_PAYLOAD;
            end
            S_END_SC:  begin hdr_byte = sc_byte(8'hB9, idx_q); last_idx = 3'd3; hdr_next = S_IDLE; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        scr_d       = scr_q;
        pts_d       = pts_q;
        id_d        = id_q;
        pts_valid_d = pts_valid_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (load) out_valid_d = 1'b0;
                if (cmd_valid) begin
                    scr_d       = cmd_scr;
                    pts_d       = cmd_pts;
                    id_d        = cmd_stream_id;
                    rem_d       = cmd_length;
                    pts_valid_d = cmd_pts_valid;
                    state_d     = cmd_end ? S_END_SC : (cmd_pack ? S_PACK_SC : S_PES_SC);
                    // Every packet opens with 0x00, so it loads on acceptance for N+1 latency.
                    if (load) begin
                        out_data_d  = 8'h00;
                        out_valid_d = 1'b1;
                        idx_d       = 3'd1;
                    end else begin
                        idx_d = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                if (load) begin
                    out_valid_d = in_valid;
                    if (in_valid) begin
                        out_data_d = in_data;
                        rem_d      = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_IDLE;
                    end
                end
            end
            default: begin
                if (load) begin
                    out_data_d  = hdr_byte;
                    out_valid_d = 1'b1;
                    if (idx_q == last_idx) begin
                        state_d = hdr_next;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            scr_q       <= '0;
            pts_q       <= '0;
            id_q        <= '0;
            pts_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            scr_q       <= scr_d;
            pts_q       <= pts_d;
            id_q        <= id_d;
            pts_valid_q <= pts_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mpeg_muxer.sv
// Bench for mpeg_muxer: randomized commands and handshakes checked against a
// byte-list model of the system stream built from the field layouts.
module tb_mpeg_muxer;

    localparam logic [21:0] RATE = 22'd3528;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic        cmd_pack = 1'b0;
    logic [32:0] cmd_scr = '0;
    logic [7:0]  cmd_stream_id = '0;
    logic [15:0] cmd_length = '0;
    logic        cmd_pts_valid = 1'b0;
    logic [32:0] cmd_pts = '0;
    logic        cmd_end = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] pay_q[$];

    // results of the most recent run_packet call
    int first_cyc, last_cyc, n_in, stall_err, inject_rdy;
    bit timeout, rdy_at_last;

    mpeg_muxer #(.MUX_RATE(RATE)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pack(cmd_pack),
        .cmd_scr(cmd_scr), .cmd_stream_id(cmd_stream_id), .cmd_length(cmd_length),
        .cmd_pts_valid(cmd_pts_valid), .cmd_pts(cmd_pts), .cmd_end(cmd_end),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic push_sc(input logic [7:0] code);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(code);
    endtask

    task automatic push_ts(input logic [63:0] v);
        exp_q.push_back(8'(64'h21 | ((v >> 29) & 64'h0E)));
        exp_q.push_back(8'((v >> 22) & 64'hFF));
        exp_q.push_back(8'(((v >> 14) & 64'hFE) | 64'h1));
        exp_q.push_back(8'((v >> 7) & 64'hFF));
        exp_q.push_back(8'(((v << 1) & 64'hFE) | 64'h1));
    endtask

    task automatic model(input bit pack, input logic [32:0] scr, input logic [7:0] id,
                         input int len, input bit ptsv, input logic [32:0] pts, input bit endc);
        int r, plen;
        exp_q.delete();
        if (endc) begin
            push_sc(8'hB9);
            return;
        end
        if (pack) begin
            push_sc(8'hBA);
            push_ts(64'(scr));
            r = int'(RATE);
            exp_q.push_back(8'(128 + ((r >> 15) & 127)));
            exp_q.push_back(8'((r >> 7) & 255));
            exp_q.push_back(8'(((r & 127) * 2) + 1));
        end
        push_sc(id);
        plen = (len + (ptsv ? 5 : 1)) % 65536;
        exp_q.push_back(8'(plen / 256));
        exp_q.push_back(8'(plen % 256));
        if (ptsv) push_ts(64'(pts));
        else      exp_q.push_back(8'h0F);
        foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    endtask

    task automatic make_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    // ---------------- driver / collector ----------------
    // Issues one command, then drives random sink/source handshakes until
    // exp_q.size() bytes are collected into got_q (bounded by a cycle budget).
    task automatic run_packet(input bit pack, input logic [32:0] scr, input logic [7:0] id,
                              input bit ptsv, input logic [32:0] pts, input bit endc,
                              input int rdy_pct, input int vld_pct, input bit inject);
        int pidx;
        bit done, have_held;
        logic [7:0] held;
        got_q.delete();
        first_cyc = -1; last_cyc = -1; n_in = 0; stall_err = 0; inject_rdy = 0;
        rdy_at_last = 1'b0; done = 1'b0; have_held = 1'b0; held = '0; pidx = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_pack = pack; cmd_scr = scr; cmd_stream_id = id;
        cmd_length = 16'(pay_q.size()); cmd_pts_valid = ptsv; cmd_pts = pts; cmd_end = endc;
        out_ready = 1'b1; in_valid = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            @(negedge clk);
            cmd_valid = inject && (cyc == 3 || cyc == 4);
            cmd_end   = cmd_valid;
            out_ready = ($urandom_range(99) < 32'(rdy_pct));
            in_valid  = ($urandom_range(99) < 32'(vld_pct));
            in_data   = (pidx < pay_q.size()) ? pay_q[pidx] : 8'($urandom);
            #1;
            if (cmd_valid && cmd_ready) inject_rdy++;
            if (have_held && !(out_valid && out_data == held)) stall_err++;
            have_held = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (in_valid && in_ready) begin
                n_in++;
                pidx++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_cyc = cyc;
                if (got_q.size() == exp_q.size()) begin
                    done = 1'b1;
                    rdy_at_last = cmd_ready;
                end
            end
        end
        timeout = !done;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_end = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %02h want 00", out_data); end
        if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset got valid=%b ready=%b want 0/1", out_valid, cmd_ready);
        end
    endtask

    task automatic test_pack_pts;
        logic [7:0] lit[26] = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01,
                                8'h80, 8'h1B, 8'h91, 8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h08,
                                8'h21, 8'h00, 8'h05, 8'hBF, 8'h21, 8'hAA, 8'hBB, 8'hCC};
        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        exp_q.delete();
        foreach (lit[i]) exp_q.push_back(lit[i]);
        run_packet(1'b1, 33'd0, 8'hE0, 1'b1, 33'd90000, 1'b0, 100, 100, 1'b0);
        n_cmp += 5;
        if (timeout) begin n_bad++; $display("FAIL pack_pts_timeout got %0d bytes want 26", got_q.size()); end
        if (first_cyc != 1) begin n_bad++; $display("FAIL pack_pts_latency got %0d want 1", first_cyc); end
        if (last_cyc != 26) begin n_bad++; $display("FAIL pack_pts_last_cycle got %0d want 26", last_cyc); end
        if (rdy_at_last !== 1'b1) begin n_bad++; $display("FAIL pack_pts_ready_at_last got %b want 1", rdy_at_last); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL pack_pts_busy_after got %b want 0", busy); end
        for (int i = 0; i < got_q.size() && i < 26; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL pack_pts byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_no_pts;
        logic [7:0] lit[9] = '{8'h00, 8'h00, 8'h01, 8'hC0, 8'h00, 8'h03, 8'h0F, 8'h11, 8'h22};
        pay_q = '{8'h11, 8'h22};
        exp_q.delete();
        foreach (lit[i]) exp_q.push_back(lit[i]);
        run_packet(1'b0, 33'd0, 8'hC0, 1'b0, 33'd0, 1'b0, 100, 100, 1'b0);
        n_cmp += 3;
        if (timeout) begin n_bad++; $display("FAIL no_pts_timeout got %0d bytes want 9", got_q.size()); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL no_pts_cmd_ready got %b want 1", cmd_ready); end
        if (n_in != 2) begin n_bad++; $display("FAIL no_pts_in_handshakes got %0d want 2", n_in); end
        for (int i = 0; i < got_q.size() && i < 9; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL no_pts byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_len;
        logic [7:0] lit[11] = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h05,
                                8'h21, 8'h00, 8'h01, 8'h00, 8'h01};
        pay_q.delete();
        exp_q.delete();
        foreach (lit[i]) exp_q.push_back(lit[i]);
        run_packet(1'b0, 33'd0, 8'hE0, 1'b1, 33'd0, 1'b0, 100, 100, 1'b0);
        n_cmp += 2;
        if (timeout) begin n_bad++; $display("FAIL zero_len_timeout got %0d bytes want 11", got_q.size()); end
        if (n_in != 0) begin n_bad++; $display("FAIL zero_len_in_ready got %0d handshakes want 0", n_in); end
        for (int i = 0; i < got_q.size() && i < 11; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL zero_len byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 4; k++) begin
            bit pack, ptsv;
            logic [32:0] scr, pts;
            logic [7:0] id;
            pack = k[0]; ptsv = k[1];
            scr  = 33'({$urandom(), $urandom()});
            pts  = 33'({$urandom(), $urandom()});
            id   = 8'($urandom);
            make_payload(64);
            model(pack, scr, id, 64, ptsv, pts, 1'b0);
            run_packet(pack, scr, id, ptsv, pts, 1'b0, 55, 60, 1'b0);
            n_cmp += 4;
            if (timeout) begin n_bad++; $display("FAIL bp%0d_timeout got %0d bytes want %0d", k, got_q.size(), exp_q.size()); end
            if (stall_err != 0) begin n_bad++; $display("FAIL bp%0d_stable got %0d changes want 0", k, stall_err); end
            if (n_in != 64) begin n_bad++; $display("FAIL bp%0d_in_handshakes got %0d want 64", k, n_in); end
            if (busy !== 1'b0) begin n_bad++; $display("FAIL bp%0d_busy_after got %b want 0", k, busy); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL bp%0d byte[%0d] got %02h want %02h", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_end_and_busy;
        logic [32:0] scr, pts;
        pay_q.delete();
        model(1'b0, 33'd0, 8'h00, 0, 1'b0, 33'd0, 1'b1);
        run_packet(1'b1, 33'h1_2345_6789, 8'hE0, 1'b1, 33'd5, 1'b1, 100, 100, 1'b0);
        n_cmp += 2;
        if (timeout) begin n_bad++; $display("FAIL end_timeout got %0d bytes want 4", got_q.size()); end
        if (got_q.size() != 4) begin n_bad++; $display("FAIL end_len got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL end byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
        scr = 33'({$urandom(), $urandom()});
        pts = 33'({$urandom(), $urandom()});
        make_payload(6);
        model(1'b1, scr, 8'hE2, 6, 1'b1, pts, 1'b0);
        run_packet(1'b1, scr, 8'hE2, 1'b1, pts, 1'b0, 80, 100, 1'b1);
        n_cmp += 2;
        if (timeout) begin n_bad++; $display("FAIL busy_cmd_timeout got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        if (inject_rdy != 0) begin n_bad++; $display("FAIL busy_cmd_ready got %0d accepts want 0", inject_rdy); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL busy_cmd byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [32:0] scr, pts;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_pack = 1'b1; cmd_end = 1'b0; cmd_scr = 33'h1_FFFF_FFFF;
        cmd_stream_id = 8'hE0; cmd_length = 16'd4; cmd_pts_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre_reset got valid=%b busy=%b want 1/1", out_valid, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        if (out_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_data got %02h want 00", out_data); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_cmd_ready got %b want 1", cmd_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        scr = 33'({$urandom(), $urandom()});
        pts = 33'({$urandom(), $urandom()});
        make_payload(5);
        model(1'b1, scr, 8'hBD, 5, 1'b1, pts, 1'b0);
        run_packet(1'b1, scr, 8'hBD, 1'b1, pts, 1'b0, 70, 70, 1'b0);
        n_cmp += 2;
        if (timeout) begin n_bad++; $display("FAIL after_reset_timeout got %0d bytes want %0d", got_q.size(), exp_q.size()); end
        if (n_in != 5) begin n_bad++; $display("FAIL after_reset_in_handshakes got %0d want 5", n_in); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL after_reset byte[%0d] got %02h want %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack_pts();
        test_no_pts();
        test_zero_len();
        test_backpressure();
        test_end_and_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
